// File: rtl/an_decode_arb.sv
// an_decode_arb: round-robin arbiter in front of a 3-stage AN-code (A=29)
// decoder. Each accepted 14-bit codeword yields quotient, residue and an error
// flag; delivered and erroneous words are counted with saturating counters.
module an_decode_arb #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  input  logic [13:0]      in0_cw,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [13:0]      in1_cw,
  output logic             in1_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_id,
  output logic [9:0]       out_q,
  output logic [4:0]       out_r,
  output logic             out_err,
  output logic [13:0]      out_cw,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  // Round-robin priority: 0 -> requester 0 wins a tie, 1 -> requester 1 wins.
  logic             r_prio;

  logic             r_s1_valid;
  logic             r_s1_id;
  logic [13:0]      r_s1_cw;
  logic [24:0]      r_s1_p;

  logic             r_s2_valid;
  logic             r_s2_id;
  logic [13:0]      r_s2_cw;
  logic [9:0]       r_s2_qt;
  logic [5:0]       r_s2_rt;

  logic             r_s3_valid;
  logic             r_s3_id;
  logic [13:0]      r_s3_cw;
  logic [9:0]       r_s3_q;
  logic [4:0]       r_s3_r;
  logic             r_s3_err;

  logic [CNT_W-1:0] r_word_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic             w_adv;
  logic             w_g0;
  logic             w_g1;
  logic             w_take;
  logic             w_hs;
  logic [13:0]      w_sel_cw;
  logic [24:0]      w_p;
  logic [9:0]       w_qt;
  logic [5:0]       w_rt;
  logic             w_fix;
  logic [9:0]       w_q;
  logic [4:0]       w_r;

  // Pipeline advance, grant selection and stage datapath arithmetic.
  always_comb begin
    w_adv     = !r_s3_valid | out_ready;
    w_g0      = in0_valid & (!in1_valid | !r_prio);
    w_g1      = in1_valid & (!in0_valid |  r_prio);
    in0_ready = w_adv & w_g0 & !rst;
    in1_ready = w_adv & w_g1 & !rst;
    w_take    = in0_ready | in1_ready;
    w_hs      = r_s3_valid & out_ready;
    w_sel_cw  = w_g0 ? in0_cw : in1_cw;
    // 1129/2^15 slightly underestimates 1/29 over the 14-bit range, so the
    // stage-2 quotient is at most one low; stage 3 corrects it.
    w_p       = 25'(w_sel_cw) * 25'd1129;
    w_qt      = 10'(r_s1_p >> 15);
    // True remainder lies in 0..57, so only its low 6 bits need keeping.
    w_rt      = 6'(r_s1_cw - w_qt * 14'd29);
    w_fix     = (r_s2_rt >= 6'd29);
    w_q       = w_fix ? (r_s2_qt + 10'd1) : r_s2_qt;
    w_r       = w_fix ? 5'(r_s2_rt - 6'd29) : r_s2_rt[4:0];
  end

  // Priority pointer moves away from whichever requester was just accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio <= 1'b0;
    end else if (w_take) begin
      r_prio <= w_g0;
    end
  end

  // Three pipeline stages, all advancing together on w_adv.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_id    <= 1'b0;
      r_s1_cw    <= '0;
      r_s1_p     <= '0;
      r_s2_valid <= 1'b0;
      r_s2_id    <= 1'b0;
      r_s2_cw    <= '0;
      r_s2_qt    <= '0;
      r_s2_rt    <= '0;
      r_s3_valid <= 1'b0;
      r_s3_id    <= 1'b0;
      r_s3_cw    <= '0;
      r_s3_q     <= '0;
      r_s3_r     <= '0;
      r_s3_err   <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid <= w_take;
      r_s1_id    <= !w_g0;
      r_s1_cw    <= w_sel_cw;
      r_s1_p     <= w_p;
      r_s2_valid <= r_s1_valid;
      r_s2_id    <= r_s1_id;
      r_s2_cw    <= r_s1_cw;
      r_s2_qt    <= w_qt;
      r_s2_rt    <= w_rt;
      r_s3_valid <= r_s2_valid;
      r_s3_id    <= r_s2_id;
      r_s3_cw    <= r_s2_cw;
      r_s3_q     <= w_q;
      r_s3_r     <= w_r;
      r_s3_err   <= (w_r != 5'd0);
    end
  end

  // Saturating statistics counters; clear wins over a same-cycle handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word_cnt <= '0;
      r_err_cnt  <= '0;
    end else if (clr_cnt) begin
      r_word_cnt <= '0;
      r_err_cnt  <= '0;
    end else if (w_hs) begin
      if (r_word_cnt != '1) r_word_cnt <= r_word_cnt + CNT_W'(1);
      if (r_s3_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign out_valid = r_s3_valid;
  assign out_id    = r_s3_id;
  assign out_q     = r_s3_q;
  assign out_r     = r_s3_r;
  assign out_err   = r_s3_err;
  assign out_cw    = r_s3_cw;
  assign word_cnt  = r_word_cnt;
  assign err_cnt   = r_err_cnt;

endmodule

// File: doc/an_decode_arb.md
AN_DECODE_ARB -- requirements
Module: an_decode_arb

Interface
REQ-001 Parameter: CNT_W, default 16, width of the statistics counters.
REQ-002 Port: clk  input  1  single clock, all state rising-edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in0_valid  input  1  requester 0 codeword valid.
REQ-005 Port: in0_cw  input  14  requester 0 AN codeword (A=29).
REQ-006 Port: in0_ready  output  1  requester 0 codeword accepted this cycle.
REQ-007 Port: in1_valid / in1_cw / in1_ready  input/input/output  1/14/1  requester 1, same meaning as requester 0.
REQ-008 Port: out_valid  output  1  decoded result valid.
REQ-009 Port: out_ready  input  1  consumer accepts result.
REQ-010 Port: out_id  output  1  requester index of the result.
REQ-011 Port: out_q  output  10  decoded quotient.
REQ-012 Port: out_r  output  5  residue mod 29.
REQ-013 Port: out_err  output  1  residue nonzero.
REQ-014 Port: out_cw  output  14  original codeword.
REQ-015 Port: clr_cnt  input  1  synchronous clear of both counters.
REQ-016 Port: word_cnt / err_cnt  output  CNT_W each  results delivered / erroneous results delivered.

Function
REQ-017 Advance enable: adv = !s3_valid | out_ready, where s3_valid is the valid bit of the last stage.
REQ-018 Arbitration: round-robin between the requesters. The priority pointer resets to 0. When both are valid, grant goes to the requester not granted last. A lone valid requester is granted regardless of the pointer. The pointer updates only on an accepted grant.
REQ-019 in0_ready = adv & grant0 and in1_ready = adv & grant1, never both 1. Ready depends on valid (no ready-before-valid guarantee).
REQ-020 Stage 1 register (on adv): valid, id, cw, and p = cw*1129 (25-bit, full precision).
REQ-021 Stage 2 register (on adv): qt = p>>15 (10 bits), and rt = cw - qt*29 (6 bits, always 0..57).
REQ-022 Stage 3 register (on adv): if rt<29 then q=qt, r=rt; else q=qt+1, r=rt-29. err = (r!=0).
REQ-023 Stage 3 drives all out_* signals directly from registers, with no combinational path from inputs.
REQ-024 Latency: an accepted codeword appears on out_valid 3 cycles later when out_ready is held high. Sustained throughput is 1 word per cycle.
REQ-025 Backpressure: while out_valid & !out_ready, all stages hold, in*_ready=0, and out_* stays stable.
REQ-026 Bubbles (no grant) propagate as valid=0. Data fields of invalid stages are don't-care but must not alter the counters.
REQ-027 Counters update on the output handshake (out_valid & out_ready). word_cnt +1 always; err_cnt +1 when out_err=1.
REQ-028 Counters saturate at 2^CNT_W-1 and do not wrap.
REQ-029 clr_cnt has priority: clear and a same-cycle handshake result in 0, and the increment is lost.
REQ-030 Ordering: results leave in acceptance order. out_id equals the id of the accepted requester.

Reset
REQ-031 rst=1 asynchronously clears all stage valid bits, the RR pointer, word_cnt and err_cnt to 0. out_valid=0, in0_ready=in1_ready=0 during reset, and all out_* data outputs are 0.
REQ-032 Reset mid-operation discards every in-flight word, with no output and no count. The first grant after release goes to requester 0 if both are valid.
REQ-033 First acceptance is possible in the first clock edge after rst deasserts.

Verification
REQ-034 in0 cw=2900, out_ready=1 -> 3 cycles later out_q=100, out_r=0, out_err=0, out_id=0 (exercises the correction path, since rt=29).
REQ-035 in1 cw=2901 -> out_q=100, out_r=1, out_err=1, out_id=1. Then cw=16383 -> out_q=564, out_r=27, out_err=1. Then cw=0 -> out_q=0, out_r=0, out_err=0. Final err_cnt=2, word_cnt=3.
REQ-036 Both requesters valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1, and out_id follows the same sequence 3 cycles later.
REQ-037 Hold out_ready=0 for 4 cycles with a full pipeline -> outputs stable, no ready, no count change. After release, 3 results drain in order with no loss or duplication.
REQ-038 Preload err_cnt to max-1 via CNT_W=2 build, then send 3 erroneous words -> err_cnt=3 (saturated). clr_cnt coincident with a handshake -> both counters 0.
REQ-039 Assert rst with 3 words in flight -> out_valid=0 immediately (asynchronous), counters 0, no stale result after release.
